// File: rtl/bus_region_decoder_if.sv
// CPU-side bus bundle for the region decoder: request, one-hot chip selects and completion status.
interface bus_region_decoder_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned NUM_REGIONS = 4
);
  logic                   reqValid;
  logic [ADDR_WIDTH-1:0]  reqAddr;
  logic [NUM_REGIONS-1:0] chipSelect;
  logic                   ready;
  logic                   busError;
  logic                   busy;

  modport master (
    output reqValid, reqAddr,
    input  chipSelect, ready, busError, busy
  );

  modport slave (
    input  reqValid, reqAddr,
    output chipSelect, ready, busError, busy
  );
endinterface

// File: rtl/bus_region_decoder.sv
// Registered memory-map decoder: base/limit windows, per-region wait states, ready strobe and
// capture of unmapped accesses into a sticky fault log.
module bus_region_decoder #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE  = {16'h0001, 16'h6000, 16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT = {16'h0000, 16'h600F, 16'hFFFF, 16'h3FFF},
  parameter logic [NUM_REGIONS*4-1:0]          REGION_WAIT  = {4'd0, 4'd2, 4'd1, 4'd0}
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_region_decoder_if.slave   bus,
  input  logic                  faultClear,
  output logic                  faultValid,
  output logic [ADDR_WIDTH-1:0] faultAddr,
  output logic [7:0]            faultCount
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;

  state_t                 state;
  logic [3:0]             waitCnt;
  logic                   hit;
  logic [NUM_REGIONS-1:0] hitSel;
  logic [3:0]             hitWait;
  logic                   enterErr;

  // First matching window wins, so overlapping maps still give a one-hot select.
  always_comb begin
    hit     = 1'b0;
    hitSel  = '0;
    hitWait = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!hit &&
          (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] <= bus.reqAddr) &&
          (bus.reqAddr <= REGION_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit       = 1'b1;
        hitSel[i] = 1'b1;
        hitWait   = REGION_WAIT[i*4 +: 4];
      end
    end
  end

  always_comb begin
    enterErr     = (state == IDLE) && bus.reqValid && !hit;
    bus.ready    = ((state == ACCESS) && (waitCnt == '0)) || (state == ERROR);
    bus.busError = (state == ERROR);
    bus.busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      waitCnt        <= '0;
      bus.chipSelect <= '0;
      faultValid     <= 1'b0;
      faultAddr      <= '0;
      faultCount     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.reqValid) begin
            if (hit) begin
              state          <= ACCESS;
              bus.chipSelect <= hitSel;
              waitCnt        <= hitWait;
            end else begin
              state <= ERROR;
            end
          end
        end
        ACCESS: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - 4'd1;
          end else begin
            state          <= IDLE;
            bus.chipSelect <= '0;
          end
        end
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase

      // A fault arriving with a clear restarts the log at this fault.
      if (enterErr) begin
        if (!faultValid || faultClear) faultAddr <= bus.reqAddr;
        faultValid <= 1'b1;
        if (faultClear)               faultCount <= 8'd1;
        else if (faultCount != 8'hFF) faultCount <= faultCount + 8'd1;
      end else if (faultClear) begin
        faultValid <= 1'b0;
        faultCount <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_region_decoder.sv
// Randomised and directed checks of bus_region_decoder against a transaction-level memory-map model.
module tb_bus_region_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        faultClear = 1'b0;
  logic        faultValid;
  logic [15:0] faultAddr;
  logic [7:0]  faultCount;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference fault log
  bit          m_valid = 1'b0;
  logic [15:0] m_addr  = '0;
  int          m_count = 0;
  bit          allow_clr = 1'b1;

  bus_region_decoder_if #(.ADDR_WIDTH(16), .NUM_REGIONS(4)) bus ();

  bus_region_decoder #(.ADDR_WIDTH(16), .NUM_REGIONS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .faultClear (faultClear),
    .faultValid (faultValid),
    .faultAddr  (faultAddr),
    .faultCount (faultCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Default map: RAM $0000-$3FFF w0, ROM $8000-$FFFF w1, UART $6000-$600F w2.
  function automatic int ref_region(input int a);
    int lo[3] = '{32'h0000, 32'h8000, 32'h6000};
    int hi[3] = '{32'h3FFF, 32'hFFFF, 32'h600F};
    for (int i = 0; i < 3; i++)
      if (a >= lo[i] && a <= hi[i]) return i;
    return -1;
  endfunction

  function automatic int ref_wait(input int r);
    int w[3] = '{0, 1, 2};
    return w[r];
  endfunction

  task automatic model_edge(input bit rst, input bit enter_err, input logic [15:0] a, input bit clr);
    if (rst) begin
      m_valid = 1'b0; m_addr = '0; m_count = 0;
    end else if (enter_err) begin
      if (!m_valid || clr) m_addr = a;
      m_valid = 1'b1;
      m_count = clr ? 1 : (m_count < 255 ? m_count + 1 : 255);
    end else if (clr) begin
      m_valid = 1'b0; m_count = 0;
    end
  endtask

  task automatic check_faults();
    check("faultValid", 32'(faultValid), 32'(m_valid));
    check("faultAddr",  32'(faultAddr),  32'(m_addr));
    check("faultCount", 32'(faultCount), 32'(m_count));
  endtask

  // Called in the low clock phase with the DUT idle; returns in the low phase, idle again.
  task automatic do_access(input logic [15:0] a, input bit clr, input int rst_at);
    int   r, w;
    bit   err;
    logic [3:0] ecs;
    r   = ref_region(int'(a));
    err = (r < 0);
    w   = err ? 0 : ref_wait(r);
    ecs = err ? 4'b0000 : 4'(1 << r);
    bus.reqValid = 1'b1;
    bus.reqAddr  = a;
    faultClear   = clr;
    @(posedge clk);
    model_edge(1'b0, err, a, clr);
    for (int c = 1; c <= w + 1; c++) begin
      @(negedge clk);
      check("chipSelect", 32'(bus.chipSelect), 32'(ecs));
      check("ready",      32'(bus.ready),      32'(c == w + 1));
      check("busError",   32'(bus.busError),   32'(err));
      check("busy",       32'(bus.busy),       32'd1);
      check_faults();
      bus.reqValid = 1'($urandom_range(0, 1));
      bus.reqAddr  = 16'($urandom);
      faultClear   = allow_clr && ($urandom_range(0, 7) == 0);
      reset        = (c == rst_at);
      @(posedge clk);
      model_edge(reset, 1'b0, '0, faultClear);
      if (reset) break;
    end
    @(negedge clk);
    reset        = 1'b0;
    bus.reqValid = 1'b0;
    faultClear   = 1'b0;
    check("idle_chipSelect", 32'(bus.chipSelect), 32'd0);
    check("idle_ready",      32'(bus.ready),      32'd0);
    check("idle_busError",   32'(bus.busError),   32'd0);
    check("idle_busy",       32'(bus.busy),       32'd0);
    check_faults();
  endtask

  initial begin
    logic [15:0] bounds [7] = '{16'h3FFF, 16'h4000, 16'h600F, 16'h6010, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] a;

    bus.reqValid = 1'b0;
    bus.reqAddr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_chipSelect", 32'(bus.chipSelect), 32'd0);
    check("rst_ready",      32'(bus.ready),      32'd0);
    check("rst_busError",   32'(bus.busError),   32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check_faults();

    // Directed: RAM and UART accesses, then the boundary sweep
    do_access(16'h0100, 1'b0, 0);
    do_access(16'h6005, 1'b0, 0);
    foreach (bounds[i]) do_access(bounds[i], 1'b0, 0);

    // Randomised traffic biased towards window edges
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       a = bounds[$urandom_range(0, 6)];
        1:       a = 16'($urandom);
        default: a = 16'h6000 + 16'($urandom_range(0, 31));
      endcase
      do_access(a, ($urandom_range(0, 7) == 0), 0);
    end

    // Fault log: first fault wins, then clear coinciding with a new fault
    allow_clr = 1'b0;
    do_access(16'h4000, 1'b1, 0);
    do_access(16'h5000, 1'b0, 0);
    check("log_addr_first", 32'(faultAddr),  32'h4000);
    check("log_count_two",  32'(faultCount), 32'd2);
    check("log_valid",      32'(faultValid), 32'd1);
    do_access(16'h7000, 1'b1, 0);
    check("clr_fault_addr",  32'(faultAddr),  32'h7000);
    check("clr_fault_count", 32'(faultCount), 32'd1);

    // Saturation over 300 unmapped accesses
    do_access(16'h4000, 1'b1, 0);
    for (int n = 1; n < 300; n++) do_access(16'h4000 + 16'(n), 1'b0, 0);
    check("sat_count", 32'(faultCount), 32'd255);
    check("sat_addr",  32'(faultAddr),  32'h4000);

    // Reset in cycle 2 of a UART access, then a ROM access
    do_access(16'h6005, 1'b0, 2);
    check("rst_mid_count", 32'(faultCount), 32'd0);
    check("rst_mid_valid", 32'(faultValid), 32'd0);
    do_access(16'h8000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_region_decoder.md
Name: bus_region_decoder

Overview:
- Parametrised, registered memory-map decoder with per-region wait states, a ready handshake and unmapped-access fault capture.
- Sits between the CPU bus interface and the RAM/ROM/UART chip selects.
- Decodes `NUM_REGIONS` base/limit windows, holds the one-hot select for the region's wait count and then pulses `ready`.
- Accesses that hit no region end with a bus error and are logged.

Parameters:
- `ADDR_WIDTH`, 16, bus address width.
- `NUM_REGIONS`, 4, number of decode windows and chip-select lines.
- `REGION_BASE`, {16'h0001, 16'h6000, 16'h8000, 16'h0000}, packed `NUM_REGIONS*ADDR_WIDTH`; region i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]; inclusive lower bound.
- `REGION_LIMIT`, {16'h0000, 16'h600F, 16'hFFFF, 16'h3FFF}, packed like `REGION_BASE`; inclusive upper bound. LIMIT < BASE disables the region, so region 3 is disabled by default.
- `REGION_WAIT`, {4'd0, 4'd2, 4'd1, 4'd0}, packed `NUM_REGIONS*4`; wait states per region (0..15).
- Default map: region 0 = RAM $0000-$3FFF (wait 0), region 1 = ROM $8000-$FFFF (wait 1), region 2 = UART $6000-$600F (wait 2).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `reqValid`  in  1  access request; sampled only in IDLE.
- `reqAddr`  in  `ADDR_WIDTH`  access address; sampled with `reqValid`.
- `chipSelect`  out  `NUM_REGIONS`  registered one-hot region select.
- `ready`  out  1  access-complete strobe, one cycle.
- `busError`  out  1  unmapped-access strobe; coincident with `ready`.
- `busy`  out  1  high whenever state is not IDLE.
- `faultValid`  out  1  sticky flag: an unmapped access occurred.
- `faultAddr`  out  `ADDR_WIDTH`  address of the first unmapped access since the last clear.
- `faultCount`  out  8  count of unmapped accesses, saturating at 255.
- `faultClear`  in  1  clears `faultValid` and `faultCount`.

Behaviour:
- **Reset (synchronous, active-high):** state=IDLE; `chipSelect`=0, `ready`=0, `busError`=0, `busy`=0, `faultValid`=0, `faultAddr`=0, `faultCount`=0. Reset mid-access abandons the access: no `ready`, `chipSelect` drops at that edge.
- **Decode (combinational, internal):**
  - Region i hits when BASE_i <= `reqAddr` <= LIMIT_i, using unsigned compares.
  - On overlap the lowest index wins, so the registered select is always one-hot or zero.
- **States:** IDLE, ACCESS, ERROR.
- **IDLE:**
  - Edge with `reqValid`=1 and a hit: go to ACCESS; `chipSelect` <= onehot(i); waitCnt <= REGION_WAIT_i.
  - Edge with `reqValid`=1 and no hit: go to ERROR; `chipSelect` stays 0.
  - `reqValid`=0: stay in IDLE.
- **ACCESS:**
  - waitCnt != 0: decrement each edge.
  - `ready`=1 combinationally while in ACCESS with waitCnt==0. The next edge returns to IDLE and clears `chipSelect`.
  - Latency: `ready` is high in the (W+1)th cycle after the accepting edge. `chipSelect` stays asserted for W+1 cycles, including the `ready` cycle.
- **ERROR:** lasts exactly one cycle with `ready`=1 and `busError`=1, then returns to IDLE.
- **Request handling:**
  - `reqValid` is ignored while `busy`=1, including the `ready` cycle.
  - Requests are never queued. Minimum spacing between accepting edges is W+2 cycles.
  - `reqAddr` need only be valid at the accepting edge; it is latched internally.
- **Fault logging, on the edge entering ERROR:**
  - If `faultValid`=0: `faultAddr` <= `reqAddr` and `faultValid` <= 1. If `faultValid`=1, `faultAddr` is held (first fault wins).
  - `faultCount` increments, saturating at 255.
- **faultClear:**
  - Clears `faultValid` and `faultCount` to 0; `faultAddr` is retained.
  - Clear and a new fault on the same edge: the new fault wins, giving `faultValid`=1, `faultAddr`=new address, `faultCount`=1.
- **Address boundaries:** all inclusive. $3FFF maps to RAM, $4000 is unmapped, $600F maps to UART, $6010 is unmapped, $7FFF is unmapped, $8000 maps to ROM, $FFFF maps to ROM.

Test Plan:
- Reset, then request $0100 → `chipSelect`=4'b0001 for 1 cycle, `ready` in cycle 1 after accept, `busError`=0, `busy` high for 1 cycle.
- Request $6005 → `chipSelect`=4'b0100 for 3 cycles, `ready` in cycle 3 only; a second `reqValid` pulse in cycles 1-3 is ignored (no extra `ready`).
- Sweep the boundaries $3FFF/$4000/$600F/$6010/$7FFF/$8000/$FFFF → selects 0001/none/0100/none/none/0010/0010. Each "none" produces `ready`=1 and `busError`=1 for 1 cycle.
- Fault log:
  - Unmapped accesses $4000 then $5000 → `faultAddr`=$4000, `faultCount`=2, `faultValid`=1.
  - `faultClear` on the same edge as an unmapped $7000 access → `faultValid`=1, `faultAddr`=$7000, `faultCount`=1.
- 300 unmapped accesses with no clear → `faultCount`=255 (saturated), `faultAddr`=first address.
- Assert `reset` in the middle of the UART access (cycle 2) → `chipSelect`=0, state IDLE, no `ready`, all fault registers 0; the next $8000 request completes with `ready` in cycle 2.
